agclk_seq: RTL
==============

Name: agclk_seq

Overview:
- Parametrised successor to the Agat bus-phase generator.
- Produces the three CPU/bus phase clocks phi_0, phi_1, phi_2 from the system clock, one bus cycle per accepted request.
- Adds a runtime step prescaler (speed modes), back-to-back cycles, RDY-style cycle stretching with timeout, and cycle status strobes.
- Sits between the system clock domain and the CPU core / video-bus arbiter.

Parameters:
CYCLE_LEN, 9, steps per bus cycle (step 0..CYCLE_LEN-1); legal range 4..16
PH0_FALL, 0, step at which phi_0 goes low
PH0_RISE, 5, step at which phi_0 returns high
PH2_FALL, 1, step at which phi_2 goes low
PH2_RISE, 7, step at which phi_2 returns high
PH1_RISE, 2, step at which phi_1 goes high
PH1_FALL, 6, step at which phi_1 returns low
HOLD_STEP, 2, step at which rdy is sampled for stretching
WAIT_MAX, 15, maximum stretch clocks before forced advance; 0 disables stretching
DIV_W, 4, width of the div input

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
ask  in  1  bus-cycle request, level-sampled
div  in  DIV_W  clocks per step minus 1; latched at cycle start
rdy  in  1  1 = proceed, 0 = stretch at HOLD_STEP
phi_0  out  1  phase 0, idle high
phi_1  out  1  phase 1, idle low
phi_2  out  1  phase 2, idle high
busy  out  1  high while a cycle is in progress
cycle_start  out  1  one-clock pulse when step 0 is entered
cycle_end  out  1  one-clock pulse on the last clock of a cycle
wait_to  out  1  one-clock pulse when a stretch is forced to end by timeout

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (n_reset).
- Reset values: phi_0=1, phi_1=0, phi_2=1; busy, cycle_start, cycle_end, wait_to = 0; state IDLE; step, prescaler and wait counter = 0.
- States:
  - IDLE: outputs at their idle values. ask=1 sampled at an edge -> at that same edge: RUN, step=0, div latched into div_l, cycle_start=1, phases loaded with the step-0 decode.
  - RUN: a prescaler counts 0..div_l. A tick occurs when prescaler==div_l; prescaler then returns to 0. On a tick the step advances by 1, so each step lasts div_l+1 clocks.
  - HOLD: entered on a tick at step HOLD_STEP when rdy=0 and WAIT_MAX!=0. Step does not advance and phases are frozen.
    - Exit to RUN with step HOLD_STEP+1 at the first edge where rdy=1.
    - Exit also when the wait counter reaches WAIT_MAX; that edge also pulses wait_to.
    - The wait counter clears on entry to HOLD.
- Phase decode (registered, updated in the same edge as step):
  - phi_0 = 0 iff PH0_FALL <= step < PH0_RISE
  - phi_2 = 0 iff PH2_FALL <= step < PH2_RISE
  - phi_1 = 1 iff PH1_RISE <= step < PH1_FALL
  - Outside RUN/HOLD all phases are at idle values.
- End of cycle: cycle_end=1 while step==CYCLE_LEN-1 and a tick is due, so it is visible for exactly one clock. On that tick:
  - ask=1 -> step=0, re-latch div, cycle_start=1. This is back-to-back with no idle clock; phases go straight to the step-0 decode.
  - ask=0 -> IDLE.
- busy = (state != IDLE).
- div changes mid-cycle are ignored until the next cycle start.
- ask is ignored while busy, except at the end-of-cycle tick.
- Simultaneous rdy=0 and the tick at the last step: rdy is ignored unless step==HOLD_STEP.
- n_reset asserted mid-cycle or mid-HOLD: immediate return to the reset values with no partial phase completion. The first cycle after release requires a fresh ask.
- Parameter check at elaboration (fatal on failure):
  - FALL < RISE for phi_0 and phi_2; RISE < FALL for phi_1
  - all edge steps <= CYCLE_LEN
  - HOLD_STEP < CYCLE_LEN-1

Decomposition:
- agclk_pkg holds:
  - state enum {IDLE, RUN, HOLD}
  - phase idle constants PHI0_IDLE=1, PHI1_IDLE=0, PHI2_IDLE=1
  - default edge-step constants
  - $clog2-based STEP_W helper
- One sub-module, agclk_presc: loadable prescaler (load div, enable, tick out, clear).
- Step FSM, phase decode and wait counter live in agclk_seq.

Test Plan:
- Defaults, div=0, ask high for 1 clock at edge k -> phi_0 low after k; phi_2 low after k+1; phi_1 high after k+2; phi_0 high after k+5; phi_1 low after k+6; phi_2 high after k+7; cycle_end at k+8; IDLE with busy=0 after k+9.
- div=3, ask held high for 2 cycles -> each step lasts 4 clocks; cycle_end at k+35; cycle_start at k+36 with phi_0 low and no idle clock; 72 clocks total.
- div=0, rdy=0 from k to k+6 -> HOLD after k+3 with phi_1=1, phi_2=0, phi_0=0 frozen; step 3 entered at the edge rdy returns high; cycle lengthened by the wait count; wait_to stays 0.
- WAIT_MAX=15, rdy held low -> exactly 15 HOLD clocks, then wait_to pulse, forced advance to step 3, normal completion.
- n_reset low during step 5 of a div=2 cycle -> outputs immediately at 1/0/1 with busy=0; after release no activity until ask.
- div changed from 0 to 7 at step 4 -> current cycle keeps 1-clock steps; the next cycle uses 8-clock steps.

Source files
------------

// File: rtl/agclk_pkg.sv
// Shared types and constants for the Agat-style bus-phase generator.
// Default edge steps reproduce the original 9-step phi_0/phi_1/phi_2 timing.
package agclk_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} agclk_state_e;

   localparam logic PHI0_IDLE = 1'b1;
   localparam logic PHI1_IDLE = 1'b0;
   localparam logic PHI2_IDLE = 1'b1;

   localparam int DEF_CYCLE_LEN = 9;
   localparam int DEF_PH0_FALL  = 0;
   localparam int DEF_PH0_RISE  = 5;
   localparam int DEF_PH2_FALL  = 1;
   localparam int DEF_PH2_RISE  = 7;
   localparam int DEF_PH1_RISE  = 2;
   localparam int DEF_PH1_FALL  = 6;
   localparam int DEF_HOLD_STEP = 2;
   localparam int DEF_WAIT_MAX  = 15;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int step_w(int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // True when step s lies in the half-open window [lo, hi).
   function automatic logic in_win(int s, int lo, int hi);
      return (s >= lo) && (s < hi);
   endfunction

endpackage

// File: rtl/agclk_seq_if.sv
// Request/phase bundle between the bus-phase generator and its users.
interface agclk_seq_if #(parameter int DIV_W = 4);
   logic             ask;
   logic [DIV_W-1:0] div;
   logic             rdy;
   logic             phi_0;
   logic             phi_1;
   logic             phi_2;
   logic             busy;
   logic             cycle_start;
   logic             cycle_end;
   logic             wait_to;

   modport master (output ask, div, rdy,
                   input  phi_0, phi_1, phi_2, busy, cycle_start, cycle_end, wait_to);
   modport slave  (input  ask, div, rdy,
                   output phi_0, phi_1, phi_2, busy, cycle_start, cycle_end, wait_to);
endinterface

// File: rtl/agclk_presc.sv
// Step prescaler: ticks once every div_l+1 enabled clocks; div_l is loaded
// only at cycle start so mid-cycle div changes never disturb a running cycle.
module agclk_presc #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   input  logic             en,
   input  logic             clr,
   output logic             tick
);
   logic [DIV_W-1:0] div_l;
   logic [DIV_W-1:0] cnt;

   assign tick = en && (cnt == div_l);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         div_l <= '0;
         cnt   <= '0;
      end else begin
         if (load) div_l <= div;
         if (clr || tick) cnt <= '0;
         else if (en)     cnt <= cnt + DIV_W'(1);
      end
   end
endmodule

// File: rtl/agclk_seq.sv
// Bus-phase generator: one phi_0/phi_1/phi_2 bus cycle per accepted ask,
// with step prescaling, back-to-back cycles and rdy stretching with timeout.
module agclk_seq
   import agclk_pkg::*;
#(
   parameter int CYCLE_LEN = DEF_CYCLE_LEN,
   parameter int PH0_FALL  = DEF_PH0_FALL,
   parameter int PH0_RISE  = DEF_PH0_RISE,
   parameter int PH2_FALL  = DEF_PH2_FALL,
   parameter int PH2_RISE  = DEF_PH2_RISE,
   parameter int PH1_RISE  = DEF_PH1_RISE,
   parameter int PH1_FALL  = DEF_PH1_FALL,
   parameter int HOLD_STEP = DEF_HOLD_STEP,
   parameter int WAIT_MAX  = DEF_WAIT_MAX,
   parameter int DIV_W     = 4
) (
   input logic        clk,
   input logic        n_reset,
   agclk_seq_if.slave bus
);
   localparam int STEP_W    = step_w(CYCLE_LEN);
   localparam int WCNT_W    = step_w(WAIT_MAX + 1);
   localparam int WAIT_LAST = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
   localparam logic [STEP_W-1:0] LAST_S  = STEP_W'(CYCLE_LEN - 1);
   localparam logic [STEP_W-1:0] HOLD_S  = STEP_W'(HOLD_STEP);
   localparam logic [STEP_W-1:0] AFTER_S = STEP_W'(HOLD_STEP + 1);
   localparam logic [WCNT_W-1:0] WLAST_C = WCNT_W'(WAIT_LAST);

   if (CYCLE_LEN < 4 || CYCLE_LEN > 16) begin : g_bad_len
      $fatal(1, "agclk_seq: CYCLE_LEN must be 4..16");
   end
   if (!(PH0_FALL < PH0_RISE && PH2_FALL < PH2_RISE && PH1_RISE < PH1_FALL)) begin : g_bad_order
      $fatal(1, "agclk_seq: phase edge order");
   end
   if (PH0_RISE > CYCLE_LEN || PH2_RISE > CYCLE_LEN || PH1_FALL > CYCLE_LEN ||
       PH0_FALL > CYCLE_LEN || PH2_FALL > CYCLE_LEN || PH1_RISE > CYCLE_LEN) begin : g_bad_edge
      $fatal(1, "agclk_seq: phase edge beyond CYCLE_LEN");
   end
   if (HOLD_STEP < 0 || HOLD_STEP >= CYCLE_LEN - 1) begin : g_bad_hold
      $fatal(1, "agclk_seq: HOLD_STEP must be below CYCLE_LEN-1");
   end

   agclk_state_e      state, state_nxt;
   logic [STEP_W-1:0] step, step_nxt;
   logic [WCNT_W-1:0] wcnt, wcnt_nxt;
   logic              tick, load, start_nxt, wto_nxt, cyc_end;
   logic              phi_0_q, phi_1_q, phi_2_q, start_q, wto_q;

   agclk_presc #(.DIV_W(DIV_W)) u_presc (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (load),
      .div     (bus.div),
      .en      (state == RUN),
      .clr     (state != RUN),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      wcnt_nxt  = wcnt;
      load      = 1'b0;
      start_nxt = 1'b0;
      wto_nxt   = 1'b0;
      cyc_end   = 1'b0;
      case (state)
         IDLE: if (bus.ask) begin
            state_nxt = RUN;
            step_nxt  = '0;
            load      = 1'b1;
            start_nxt = 1'b1;
         end
         RUN: if (tick) begin
            if (step == LAST_S) begin
               cyc_end  = 1'b1;
               step_nxt = '0;
               if (bus.ask) begin
                  load      = 1'b1;
                  start_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (step == HOLD_S && !bus.rdy && WAIT_MAX != 0) begin
               state_nxt = HOLD;
               wcnt_nxt  = '0;
            end else begin
               step_nxt = step + STEP_W'(1);
            end
         end
         HOLD: begin
            // rdy wins over a timeout landing on the same edge
            if (bus.rdy || wcnt == WLAST_C) begin
               state_nxt = RUN;
               step_nxt  = AFTER_S;
               wto_nxt   = !bus.rdy;
            end else begin
               wcnt_nxt = wcnt + WCNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= IDLE;
         step    <= '0;
         wcnt    <= '0;
         phi_0_q <= PHI0_IDLE;
         phi_1_q <= PHI1_IDLE;
         phi_2_q <= PHI2_IDLE;
         start_q <= 1'b0;
         wto_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         step    <= step_nxt;
         wcnt    <= wcnt_nxt;
         start_q <= start_nxt;
         wto_q   <= wto_nxt;
         // Phases follow the step being entered, so they change on the same edge.
         if (state_nxt == IDLE) begin
            phi_0_q <= PHI0_IDLE;
            phi_1_q <= PHI1_IDLE;
            phi_2_q <= PHI2_IDLE;
         end else begin
            phi_0_q <= !in_win(int'(step_nxt), PH0_FALL, PH0_RISE);
            phi_1_q <=  in_win(int'(step_nxt), PH1_RISE, PH1_FALL);
            phi_2_q <= !in_win(int'(step_nxt), PH2_FALL, PH2_RISE);
         end
      end
   end

   assign bus.phi_0       = phi_0_q;
   assign bus.phi_1       = phi_1_q;
   assign bus.phi_2       = phi_2_q;
   assign bus.busy        = (state != IDLE);
   assign bus.cycle_start = start_q;
   assign bus.cycle_end   = cyc_end;
   assign bus.wait_to     = wto_q;
endmodule
